// File: rtl/probe_unit_q.sv
// Coherence probe handler: queues outer-memory probes and runs each through a
// meta read, an MSHR conflict check, a release or writeback, and a meta update.
module probe_unit_q #(
    parameter  int WAYS     = 4,
    parameter  int IDX_BITS = 6,
    parameter  int BLK_BITS = 26,
    parameter  int QDEPTH   = 2,
    localparam int TAG_BITS = BLK_BITS - IDX_BITS,
    localparam int CW       = $clog2(QDEPTH + 1)
) (
    input  logic                clk,
    input  logic                reset,

    input  logic                req_valid,
    output logic                req_ready,
    input  logic [BLK_BITS-1:0] req_addr_block,
    input  logic [1:0]          req_p_type,

    output logic                meta_read_valid,
    input  logic                meta_read_ready,
    output logic [IDX_BITS-1:0] meta_read_idx,
    output logic [TAG_BITS-1:0] meta_read_tag,

    input  logic [WAYS-1:0]     way_en,
    input  logic [1:0]          block_state,
    input  logic                mshr_rdy,

    output logic                rep_valid,
    input  logic                rep_ready,
    output logic [BLK_BITS-1:0] rep_addr_block,
    output logic [2:0]          rep_r_type,

    output logic                wb_req_valid,
    input  logic                wb_req_ready,
    output logic [BLK_BITS-1:0] wb_req_addr_block,
    output logic [2:0]          wb_req_r_type,
    output logic [WAYS-1:0]     wb_req_way_en,
    input  logic                wb_done,

    output logic                meta_write_valid,
    input  logic                meta_write_ready,
    output logic [IDX_BITS-1:0] meta_write_idx,
    output logic [WAYS-1:0]     meta_write_way_en,
    output logic [TAG_BITS-1:0] meta_write_tag,
    output logic [1:0]          meta_write_coh,

    output logic                busy,
    output logic [CW-1:0]       q_count,
    output logic [7:0]          retry_cnt
);

    localparam int PW = $clog2(QDEPTH);

    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_META_READ  = 4'd1,
        S_META_RESP  = 4'd2,
        S_MSHR_CHK   = 4'd3,
        S_DECIDE     = 4'd4,
        S_RELEASE    = 4'd5,
        S_WB_REQ     = 4'd6,
        S_WB_WAIT    = 4'd7,
        S_META_WRITE = 4'd8
    } state_t;

    state_t r_state, w_next;

    logic [BLK_BITS-1:0] r_q_addr  [QDEPTH];
    logic [1:0]          r_q_ptype [QDEPTH];
    logic [PW-1:0]       r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]       r_count;

    logic [BLK_BITS-1:0] r_addr;
    logic [1:0]          r_ptype;
    logic [WAYS-1:0]     r_way;
    logic [1:0]          r_old;
    logic [7:0]          r_retry;

    logic       w_push, w_pop, w_hit, w_dirty;
    logic [1:0] w_coh;
    logic [2:0] w_rtype;

    // No bypass: a full queue refuses a push even when the head is popping.
    assign req_ready = (r_count < CW'(QDEPTH));
    assign w_push    = req_valid & req_ready;
    assign w_pop     = (r_state == S_IDLE) && (r_count != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: queue storage has no reset; occupancy is tracked by r_count, so
    // stale entries are never observed.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_addr[r_wr_ptr]  <= req_addr_block;
            r_q_ptype[r_wr_ptr] <= req_p_type;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr  <= '0;
            r_ptype <= '0;
            r_way   <= '0;
            r_old   <= '0;
            r_retry <= '0;
        end else begin
            if (w_pop) begin
                r_addr  <= r_q_addr[r_rd_ptr];
                r_ptype <= r_q_ptype[r_rd_ptr];
            end
            if (r_state == S_MSHR_CHK) begin
                r_way <= way_en;
                r_old <= block_state;
                if (!mshr_rdy && r_retry != 8'hFF) r_retry <= r_retry + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    assign w_hit   = |r_way;
    assign w_dirty = (r_old == 2'd3);

    // NOTE: w_next gets a default before the case so no latch is inferred.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:       if (r_count != '0) w_next = S_META_READ;
            S_META_READ:  if (meta_read_ready) w_next = S_META_RESP;
            S_META_RESP:  w_next = S_MSHR_CHK;
            S_MSHR_CHK:   w_next = mshr_rdy ? S_DECIDE : S_META_READ;
            S_DECIDE:     w_next = (w_hit && w_dirty) ? S_WB_REQ : S_RELEASE;
            S_RELEASE:    if (rep_ready) w_next = w_hit ? S_META_WRITE : S_IDLE;
            S_WB_REQ:     if (wb_req_ready) w_next = S_WB_WAIT;
            S_WB_WAIT:    if (wb_done) w_next = S_META_WRITE;
            S_META_WRITE: if (meta_write_ready) w_next = S_IDLE;
            default:      w_next = S_IDLE;
        endcase
    end

    assign w_coh = w_hit ? r_old : 2'd0;

    always_comb begin
        w_rtype = 3'd3;
        case (r_ptype)
            2'd0:    w_rtype = (w_coh == 2'd3) ? 3'd0 : 3'd3;
            2'd1:    w_rtype = (w_coh == 2'd3) ? 3'd1 : 3'd4;
            2'd2:    w_rtype = (w_coh == 2'd3) ? 3'd2 : 3'd5;
            default: w_rtype = 3'd3;
        endcase
    end

    always_comb begin
        meta_read_valid  = (r_state == S_META_READ);
        rep_valid        = (r_state == S_RELEASE);
        wb_req_valid     = (r_state == S_WB_REQ);
        meta_write_valid = (r_state == S_META_WRITE);
        busy             = (r_state != S_IDLE);

        // Reply types read as zero while idle so reset leaves every data output at 0.
        rep_r_type    = rep_valid    ? w_rtype : 3'd0;
        wb_req_r_type = wb_req_valid ? w_rtype : 3'd0;

        case (r_ptype)
            2'd0:    meta_write_coh = 2'd0;
            2'd1:    meta_write_coh = 2'd1;
            default: meta_write_coh = r_old;
        endcase
    end

    assign meta_read_idx     = r_addr[IDX_BITS-1:0];
    assign meta_read_tag     = r_addr[BLK_BITS-1:IDX_BITS];
    assign meta_write_idx    = r_addr[IDX_BITS-1:0];
    assign meta_write_tag    = r_addr[BLK_BITS-1:IDX_BITS];
    assign meta_write_way_en = r_way;
    assign rep_addr_block    = r_addr;
    assign wb_req_addr_block = r_addr;
    assign wb_req_way_en     = r_way;
    assign q_count           = r_count;
    assign retry_cnt         = r_retry;

endmodule
